signed_shift_left_sat_serial: RTL and testbench

SIGNED_SHIFT_LEFT_SAT_SERIAL -- requirements
Module: signed_shift_left_sat_serial

---
 rtl/signed_shift_left_sat_serial.sv | 110 +++++++++++
 tb/tb_signed_shift_left_sat_serial.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_shift_left_sat_serial.sv
// Serial saturating arithmetic left shift: a * 2^s computed one bit per clock.
// A ready/valid handshake on each side; one operand in flight at a time.
// The result register holds its value while the sink stalls.
module signed_shift_left_sat_serial #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] s,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  res,
   output logic          ovf
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

   logic [1:0]    state;
   logic [SW-1:0] count;
   logic [N-1:0]  work;
   logic          sign_a;
   logic          sticky;
   logic [N-1:0]  res_q;
   logic          ovf_q;

   logic          step_ovf;
   logic [N-1:0]  work_shifted;
   logic          final_ovf;
   logic [N-1:0]  sat_value;

   // One shift step: a bit is lost whenever the two top bits differ, since
   // the sign bit would change. Saturation direction follows the original sign.
   always_comb begin
      step_ovf     = work[N-1] ^ work[N-2];
      work_shifted = {work[N-2:0], 1'b0};
      final_ovf    = sticky | step_ovf;
      sat_value    = sign_a ? MAX_NEG : MAX_POS;
   end

   // Control FSM and datapath. Shift counts at or above N (only reachable when
   // N is not a power of two) need no special case: any nonzero operand
   // eventually shifts a mismatching bit into the sign and saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         work   <= '0;
         sign_a <= 1'b0;
         sticky <= 1'b0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work   <= a;
                  count  <= s;
                  sign_a <= a[N-1];
                  sticky <= 1'b0;
                  if (s == '0) begin
                     res_q <= a;
                     ovf_q <= 1'b0;
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= work_shifted;
               count <= count - SW'(1);
               if (step_ovf) begin
                  sticky <= 1'b1;
               end
               if (count == SW'(1)) begin
                  res_q <= final_ovf ? sat_value : work_shifted;
                  ovf_q <= final_ovf;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake flags decode straight from the state register.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      res       = res_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_signed_shift_left_sat_serial.sv
// Self-checking bench for signed_shift_left_sat_serial (N = 8).
// Directed vector table, reset-abort sequence, and a randomized run checked
// against an arithmetic clamp model.
module tb_signed_shift_left_sat_serial;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [SW-1:0] s;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  res;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      int         s;
      int         hold;
      logic [7:0] expRes;
      logic       expOvf;
   } vec_t;

   vec_t vecs[12];

   signed_shift_left_sat_serial #(.N(N), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .ovf       (ovf)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: exact product, then clamp to the signed 8-bit range.
   function automatic void refModel(input logic [7:0] av, input int sv,
                                    output logic [7:0] r, output logic o);
      int p;
      p = int'($signed(av)) * (1 << sv);
      if (p > 127) begin
         r = 8'h7F;
         o = 1'b1;
      end else if (p < -128) begin
         r = 8'h80;
         o = 1'b1;
      end else begin
         r = p[7:0];
         o = 1'b0;
      end
   endfunction

   // Run one operand through the block. Called at a falling edge.
   // hold = cycles to stall the sink once out_valid appears; noise scrambles
   // inputs while the operation is in flight.
   task automatic applyStimulus(input logic [7:0] av, input int sv, input int hold,
                                input bit noise, output logic [7:0] gotRes,
                                output logic gotOvf, output int lat);
      int waitCnt;
      logic [7:0] heldRes;
      logic heldOvf;
      bit stable;
      waitCnt = 0;
      while (!in_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("in_ready_before_accept", int'(in_ready), 1);
      a         = av;
      s         = SW'(sv);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      if (noise) begin
         in_valid = 1'($urandom);
         a        = 8'($urandom);
         s        = SW'($urandom);
      end
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (noise) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            s        = SW'($urandom);
         end
      end
      if (!out_valid) lat = -1;
      gotRes  = res;
      gotOvf  = ovf;
      heldRes = res;
      heldOvf = ovf;
      stable  = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (res !== heldRes || ovf !== heldOvf || out_valid !== 1'b1 || in_ready !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) checkOutput("hold_stable", int'(stable), 1);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("pop_in_ready", int'(in_ready), 1);
      checkOutput("pop_out_valid", int'(out_valid), 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Main sequence: reset, directed table, reset abort, random regression.
   initial begin
      logic [7:0] gotRes;
      logic       gotOvf;
      int         lat;
      logic [7:0] expRes;
      logic       expOvf;
      int         seen;
      int         sv;
      int         gap;

      vecs[0]  = '{8'h05, 3, 0, 8'h28, 1'b0};
      vecs[1]  = '{8'hFD, 2, 0, 8'hF4, 1'b0};
      vecs[2]  = '{8'hF0, 3, 1, 8'h80, 1'b0};
      vecs[3]  = '{8'h14, 3, 0, 8'h7F, 1'b1};
      vecs[4]  = '{8'h80, 1, 2, 8'h80, 1'b1};
      vecs[5]  = '{8'h00, 7, 0, 8'h00, 1'b0};
      vecs[6]  = '{8'h9A, 0, 3, 8'h9A, 1'b0};
      vecs[7]  = '{8'h7F, 7, 0, 8'h7F, 1'b1};
      vecs[8]  = '{8'hFF, 7, 0, 8'h80, 1'b0};
      vecs[9]  = '{8'h01, 6, 0, 8'h40, 1'b0};
      vecs[10] = '{8'h01, 7, 1, 8'h7F, 1'b1};
      vecs[11] = '{8'hC0, 1, 0, 8'h80, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      s         = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_res", int'(res), 0);
      checkOutput("reset_ovf", int'(ovf), 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].a, vecs[i].s, vecs[i].hold, 1'b0, gotRes, gotOvf, lat);
         checkOutput($sformatf("vec%0d_res", i), int'(gotRes), int'(vecs[i].expRes));
         checkOutput($sformatf("vec%0d_ovf", i), int'(gotOvf), int'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].s + 1);
      end

      // Reset during SHIFT abandons the operand.
      a        = 8'h05;
      s        = 3'd6;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_out_valid", int'(out_valid), 0);
      checkOutput("abort_in_ready", int'(in_ready), 1);
      checkOutput("abort_res", int'(res), 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("abort_no_out_valid", seen, 0);
      applyStimulus(8'h01, 1, 0, 1'b0, gotRes, gotOvf, lat);
      checkOutput("after_abort_res", int'(gotRes), 2);
      checkOutput("after_abort_ovf", int'(gotOvf), 0);
      checkOutput("after_abort_latency", lat, 2);

      // Random regression with idle gaps, sink stalls and input noise.
      for (int k = 0; k < 1000; k++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            a = 8'($urandom);
            @(negedge clk);
         end
         sv = $urandom_range(0, 7);
         a  = 8'($urandom);
         refModel(a, sv, expRes, expOvf);
         applyStimulus(a, sv, $urandom_range(0, 2), 1'b1, gotRes, gotOvf, lat);
         checkOutput($sformatf("rand%0d_res", k), int'(gotRes), int'(expRes));
         checkOutput($sformatf("rand%0d_ovf", k), int'(gotOvf), int'(expOvf));
         checkOutput($sformatf("rand%0d_latency", k), lat, sv + 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
